axis_frame_rx: RTL and testbench
================================

Name: axis_frame_rx

Overview:
- Parametrised AXI-Stream slave front end for the FFT core.
- Accepts one frame of complex samples, packed LANES per beat, through a FIFO.
- Serialises the beats to one sample per cycle and writes them into the activation memory port.
- Checks frame length against TLAST and reports done and error status to the top-level controller.

Parameters:
- SAMPLE_WDT, 16, width of one real or imaginary component.
- LANES, 2, complex samples per beat (power of two, 1..8); TDATA width = 2*LANES*SAMPLE_WDT.
- FRAME_LEN_LOG2, 10, log2 of samples per frame (FFT size); must be >= log2(LANES).
- FIFO_ADDR_WDT, 4, FIFO depth = 2**FIFO_ADDR_WDT beats.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- S_AXIS_TDATA  in  2*LANES*SAMPLE_WDT  beat; lane k = TDATA[2*SAMPLE_WDT*k +: 2*SAMPLE_WDT], im in the low half, re in the high half
- S_AXIS_TLAST  in  1  last beat of frame
- S_AXIS_TVALID  in  1  beat valid
- S_AXIS_TREADY  out  1  beat accept
- s_axis_if_addr  out  FRAME_LEN_LOG2  sample write address
- data_re_0_in  out  SAMPLE_WDT  real part
- data_im_0_in  out  SAMPLE_WDT  imaginary part
- push  out  1  memory write strobe
- comp_busy  in  1  FFT engine busy; blocks frame start
- m_axis_if_busy  in  1  master interface busy; blocks frame start
- rx_done  out  1  one-cycle pulse when the frame is fully written
- rx_err  out  2  [0] short frame, [1] long frame; valid with rx_done, held until next frame start
- s_axis_if_busy  out  1  high whenever state != S_IDLE

Behaviour:
- Reset clears: all outputs 0, state S_IDLE, FIFO pointers and count 0, serialiser empty, beat counter 0. Reset mid-frame discards FIFO contents, and no rx_done is issued.
- S_AXIS_TREADY is decoded from registers only: state == S_RECV and FIFO not full, or state == S_FLUSH. There is no combinational path from TVALID.
- A beat is accepted on TVALID & TREADY. TDATA is written to the FIFO except in S_FLUSH.
- FSM:
  - S_IDLE -> S_RECV when !comp_busy & !m_axis_if_busy. This transition clears rx_err and the beat counter.
  - S_RECV, on an accepted beat with TLAST, when the beat counter == BEATS-1 (BEATS = 2**FRAME_LEN_LOG2/LANES) -> S_DRAIN.
  - S_RECV, on an accepted beat with TLAST, when the counter < BEATS-1 -> S_DRAIN, set rx_err[0].
  - S_RECV, on an accepted beat with counter == BEATS-1 and no TLAST -> S_FLUSH, set rx_err[1].
  - S_FLUSH: accepts and discards beats; on an accepted TLAST beat -> S_DRAIN.
  - S_DRAIN -> S_DONE when the FIFO is empty, the serialiser is empty and no read is in flight.
  - S_DONE: rx_done = 1 for exactly this cycle, then -> S_IDLE.
- FIFO:
  - Count-based full/empty with count width FIFO_ADDR_WDT+1.
  - Simultaneous push and pop is legal at any fill level except empty-pop. Pointers wrap modulo depth.
  - Registered read: data is available 1 cycle after pop.
- Serialiser:
  - Holds one beat and emits lane 0 first, one lane per cycle with push = 1.
  - Pops the next beat so that sustained throughput is one push per cycle with no bubbles while the FIFO is non-empty.
  - Accepted beat to first push is exactly 2 cycles when the FIFO and serialiser are empty.
- Address: sample counter, 0 at frame start, +1 after each push, wrap-free by construction. A short frame leaves the remaining addresses unwritten.
- Beat counter has width FRAME_LEN_LOG2-log2(LANES)+1 and saturates at BEATS.
- Frame start is not re-evaluated mid-frame: comp_busy asserting mid-frame has no effect.

Optional Feature:
- AXIS_FRAME_RX_BITREV_EN:
  - Defined: s_axis_if_addr outputs the bit-reversed FRAME_LEN_LOG2-bit sample counter. Data, push and timing are unchanged.
  - Undefined: natural-order addressing.

Decomposition:
- axi_stream_pckg holds:
  - rx_state_t enum (S_IDLE, S_RECV, S_FLUSH, S_DRAIN, S_DONE)
  - RX_ERR_SHORT / RX_ERR_LONG bit indices
  - bit-reverse function
- Sub-module axis_rx_fifo: parametrised synchronous FIFO (DATA_WDT, ADDR_WDT), registered read, full/empty/count outputs, with assertions for write-on-full and read-on-empty.

Test Plan (SAMPLE_WDT=16, LANES=2, FRAME_LEN_LOG2=4, FIFO_ADDR_WDT=2; BEATS=8):
- Nominal frame: 8 back-to-back beats, lane data re=n, im=-n, TLAST on beat 7 -> 16 consecutive pushes, addr 0..15, first push 2 cycles after beat 0, rx_done once, rx_err=0.
- Backpressure:
  - TVALID held high with comp_busy=1 -> TREADY=0 and busy=0.
  - Release comp_busy -> frame accepted.
  - TVALID toggling randomly -> data and order unchanged, FIFO count never exceeds 4.
- Short frame: TLAST on beat 4 -> 10 pushes (addr 0..9), rx_done with rx_err=2'b01.
- Long frame: 11 beats, TLAST on beat 10 -> 16 pushes only, beats 8..10 accepted and discarded, rx_err=2'b10.
- Reset: rst_n=0 for 1 cycle after beat 3 -> all outputs 0 next cycle, no rx_done. A following nominal frame passes.
- With AXIS_FRAME_RX_BITREV_EN: nominal frame -> addr sequence 0,8,4,12,2,...,15 with the same data order.

Source files
------------

// File: rtl/axi_stream_pckg.sv
// Shared types and helpers for the AXI-Stream frame receiver.
package axi_stream_pckg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } rx_state_t;

  localparam int unsigned RX_ERR_SHORT = 0;
  localparam int unsigned RX_ERR_LONG  = 1;

  // Reverse the low wdt bits of val; bits above wdt come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] val, input int unsigned wdt);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(wdt)) res[int'(wdt) - 1 - i] = val[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rx_fifo.sv
// Synchronous count-based FIFO with a registered read port (data valid one cycle after rd_en).
module axis_rx_fifo #(
  parameter int unsigned DATA_WDT = 32,
  parameter int unsigned ADDR_WDT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DATA_WDT-1:0] wr_data,
  input  logic                rd_en,
  output logic [DATA_WDT-1:0] rd_data,
  output logic                full,
  output logic                empty,
  output logic [ADDR_WDT:0]   count
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WDT;
  localparam int unsigned CNT_WDT = ADDR_WDT + 1;

  logic [DATA_WDT-1:0] mem [DEPTH];
  logic [ADDR_WDT-1:0] wr_ptr;
  logic [ADDR_WDT-1:0] rd_ptr;
  logic                do_wr;
  logic                do_rd;

  assign full  = (count == CNT_WDT'(DEPTH));
  assign empty = (count == '0);
  // A write into a full FIFO is fine when a read frees a slot in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_wr_on_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full && !rd_en));
  a_no_rd_on_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty));

endmodule

// File: rtl/axis_frame_rx.sv
// AXI-Stream frame receiver: buffers beats, serialises lanes into the activation memory, checks TLAST.
// Build option AXIS_FRAME_RX_BITREV_EN: bit-reversed sample addressing instead of natural order.
module axis_frame_rx
  import axi_stream_pckg::*;
#(
  parameter int unsigned SAMPLE_WDT     = 16,
  parameter int unsigned LANES          = 2,
  parameter int unsigned FRAME_LEN_LOG2 = 10,
  parameter int unsigned FIFO_ADDR_WDT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*LANES*SAMPLE_WDT-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TLAST,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  output logic [FRAME_LEN_LOG2-1:0]     s_axis_if_addr,
  output logic [SAMPLE_WDT-1:0]         data_re_0_in,
  output logic [SAMPLE_WDT-1:0]         data_im_0_in,
  output logic                          push,
  input  logic                          comp_busy,
  input  logic                          m_axis_if_busy,
  output logic                          rx_done,
  output logic [1:0]                    rx_err,
  output logic                          s_axis_if_busy
);

  localparam int unsigned TDATA_WDT    = 2 * LANES * SAMPLE_WDT;
  localparam int unsigned LANE_WDT     = 2 * SAMPLE_WDT;
  localparam int unsigned LANE_LOG2    = $clog2(LANES);
  localparam int unsigned LANE_IDX_WDT = (LANE_LOG2 == 0) ? 1 : LANE_LOG2;
  localparam int unsigned BEATS        = (2 ** FRAME_LEN_LOG2) / LANES;
  localparam int unsigned BEAT_WDT     = FRAME_LEN_LOG2 - LANE_LOG2 + 1;
  localparam int unsigned FIFO_DEPTH   = 2 ** FIFO_ADDR_WDT;
  localparam int unsigned CNT_WDT      = FIFO_ADDR_WDT + 1;

  rx_state_t               state;
  logic [BEAT_WDT-1:0]     beat_cnt;
  logic [FRAME_LEN_LOG2-1:0] sample_cnt;
  logic [LANE_IDX_WDT-1:0] lane;
  logic                    ser_full;
  logic                    last_lane;
  logic                    beat_acc;
  logic                    start;
  logic                    fifo_wr;
  logic                    fifo_rd;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_WDT-1:0]      fifo_count;
  logic [TDATA_WDT-1:0]    fifo_rd_data;
  logic [LANE_WDT-1:0]     lane_data;

  // Ready depends on state and FIFO fill only, never on TVALID.
  assign S_AXIS_TREADY = ((state == S_RECV) && !fifo_full) || (state == S_FLUSH);
  assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign fifo_wr       = beat_acc && (state == S_RECV);
  assign start         = (state == S_IDLE) && !comp_busy && !m_axis_if_busy;

  // The FIFO output register doubles as the serialiser beat holder; refill on the last lane keeps pushes gap-free.
  assign last_lane = (lane == LANE_IDX_WDT'(LANES - 1));
  assign fifo_rd   = !fifo_empty && (!ser_full || last_lane);

  axis_rx_fifo #(
    .DATA_WDT (TDATA_WDT),
    .ADDR_WDT (FIFO_ADDR_WDT)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (S_AXIS_TDATA),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    lane_data = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (ser_full && (lane == LANE_IDX_WDT'(k))) lane_data = fifo_rd_data[LANE_WDT*k +: LANE_WDT];
    end
  end

  assign data_re_0_in = lane_data[LANE_WDT-1:SAMPLE_WDT];
  assign data_im_0_in = lane_data[SAMPLE_WDT-1:0];
  assign push         = ser_full;

`ifdef AXIS_FRAME_RX_BITREV_EN
  assign s_axis_if_addr = FRAME_LEN_LOG2'(bit_rev(32'(sample_cnt), FRAME_LEN_LOG2));
`else
  assign s_axis_if_addr = sample_cnt;
`endif

  // Serialiser lane sequencing and sample address counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ser_full   <= 1'b0;
      lane       <= '0;
      sample_cnt <= '0;
    end else begin
      ser_full <= fifo_rd || (ser_full && !last_lane);
      if (fifo_rd) lane <= '0;
      else if (ser_full) lane <= lane + 1'b1;
      if (start) sample_cnt <= '0;
      else if (ser_full) sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // Frame control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      beat_cnt       <= '0;
      rx_err         <= '0;
      rx_done        <= 1'b0;
      s_axis_if_busy <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (beat_acc && (beat_cnt != BEAT_WDT'(BEATS))) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_RECV;
            rx_err         <= '0;
            beat_cnt       <= '0;
            s_axis_if_busy <= 1'b1;
          end
        end
        S_RECV: begin
          if (beat_acc) begin
            if (S_AXIS_TLAST) begin
              state <= S_DRAIN;
              if (beat_cnt < BEAT_WDT'(BEATS - 1)) rx_err[RX_ERR_SHORT] <= 1'b1;
            end else if (beat_cnt == BEAT_WDT'(BEATS - 1)) begin
              state               <= S_FLUSH;
              rx_err[RX_ERR_LONG] <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (beat_acc && S_AXIS_TLAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // The final lane may still be pushing this cycle; nothing follows it.
          if (fifo_empty && (!ser_full || last_lane)) begin
            state   <= S_DONE;
            rx_done <= 1'b1;
          end
        end
        S_DONE: begin
          state          <= S_IDLE;
          s_axis_if_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CNT_WDT'(FIFO_DEPTH));

endmodule

// File: tb/tb_axis_frame_rx.sv
// Randomised scoreboard bench for axis_frame_rx (LANES=2, 16-sample frames, 4-deep FIFO).
module tb_axis_frame_rx;

  localparam int SW    = 16;
  localparam int LN    = 2;
  localparam int FLOG  = 4;
  localparam int FAW   = 2;
  localparam int BEATS = (1 << FLOG) / LN;
  localparam int DW    = 2 * LN * SW;

  typedef struct {
    logic [FLOG-1:0] addr;
    logic [SW-1:0]   re;
    logic [SW-1:0]   im;
  } push_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   tdata;
  logic            tlast;
  logic            tvalid;
  logic            tready;
  logic [FLOG-1:0] addr;
  logic [SW-1:0]   re;
  logic [SW-1:0]   im;
  logic            push;
  logic            comp_busy;
  logic            m_busy;
  logic            rx_done;
  logic [1:0]      rx_err;
  logic            busy;

  axis_frame_rx #(
    .SAMPLE_WDT     (SW),
    .LANES          (LN),
    .FRAME_LEN_LOG2 (FLOG),
    .FIFO_ADDR_WDT  (FAW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .S_AXIS_TDATA   (tdata),
    .S_AXIS_TLAST   (tlast),
    .S_AXIS_TVALID  (tvalid),
    .S_AXIS_TREADY  (tready),
    .s_axis_if_addr (addr),
    .data_re_0_in   (re),
    .data_im_0_in   (im),
    .push           (push),
    .comp_busy      (comp_busy),
    .m_axis_if_busy (m_busy),
    .rx_done        (rx_done),
    .rx_err         (rx_err),
    .s_axis_if_busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  push_t exp_q[$];
  logic [1:0] done_q[$];
  bit mon_en = 1'b1;
  int stray_done = 0;
  int max_cnt = 0;
  bit lat_arm = 1'b0;
  int first_push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [FLOG-1:0] exp_addr(input int n);
    logic [FLOG-1:0] v;
    v = FLOG'(n);
`ifdef AXIS_FRAME_RX_BITREV_EN
    return {v[0], v[1], v[2], v[3]};
`else
    return v;
`endif
  endfunction

  // Sample n of a frame: re = base+n, im = -(base+n); lane k of beat b is sample b*LANES+k.
  function automatic logic [DW-1:0] mk_beat(input int base, input int b);
    logic [DW-1:0] d;
    int v;
    d = '0;
    for (int k = 0; k < LN; k++) begin
      v = base + b * LN + k;
      d[2*SW*k +: 2*SW] = {SW'(v), SW'(-v)};
    end
    return d;
  endfunction

  // Monitor: pops the scoreboard on every push and rx_done.
  always @(negedge clk) begin
    push_t e;
    if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
    if (rst_n && mon_en && push) begin
      if (lat_arm) begin
        first_push_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (exp_q.size() == 0) chk("push_unexpected", 32'(push), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("push_addr", 32'(addr), 32'(e.addr));
        chk("push_re", 32'(re), 32'(e.re));
        chk("push_im", 32'(im), 32'(e.im));
      end
    end
    if (rst_n && rx_done) begin
      if (!mon_en) stray_done++;
      else if (done_q.size() == 0) chk("done_unexpected", 32'(rx_done), 32'd0);
      else begin
        chk("done_pushes_left", 32'(exp_q.size()), 32'd0);
        chk("done_err", 32'(rx_err), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input bit rnd, output int acc_cyc);
    int n;
    bit hs;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = {$urandom, $urandom};
        @(posedge clk); #1;
      end
    end
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    n = 0;
    hs = 1'b0;
    acc_cyc = 0;
    do begin
      @(negedge clk);
      hs = tready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 200);
    if (!hs) chk("beat_accept_timeout", 32'(hs), 32'd1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Issue one frame whose TLAST sits on beat last_idx; the model decides what the memory should see.
  task automatic send_frame(input int last_idx, input int base, input bit rnd, input bit expect_out, output int acc0);
    int written;
    logic [1:0] err;
    int a;
    written = (last_idx < BEATS) ? last_idx + 1 : BEATS;
    err = (last_idx < BEATS - 1) ? 2'b01 : (last_idx == BEATS - 1) ? 2'b00 : 2'b10;
    if (expect_out) begin
      for (int n = 0; n < written * LN; n++)
        exp_q.push_back('{addr: exp_addr(n), re: SW'(base + n), im: SW'(-(base + n))});
      done_q.push_back(err);
    end
    acc0 = 0;
    for (int b = 0; b <= last_idx; b++) begin
      if (rnd && b > 0) begin
        comp_busy = 1'($urandom_range(0, 1));
        m_busy    = 1'($urandom_range(0, 1));
      end
      send_beat(mk_beat(base, b), (b == last_idx), rnd, a);
      if (b == 0) acc0 = a;
    end
    comp_busy = 1'b0;
    m_busy    = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_complete", 32'(exp_q.size() + done_q.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tready"}, 32'(tready), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_data"}, 32'({re, im}), 32'd0);
    chk({tag, "_push"}, 32'(push), 32'd0);
    chk({tag, "_done"}, 32'(rx_done), 32'd0);
    chk({tag, "_err"}, 32'(rx_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acc0;
    int dummy;
    rst_n = 1'b0;
    tdata = '0;
    tlast = 1'b0;
    tvalid = 1'b0;
    comp_busy = 1'b1;
    m_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");

    // Engine busy: a waiting beat must not be taken and the receiver stays idle.
    rst_n = 1'b1;
    tvalid = 1'b1;
    tdata = mk_beat(0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy_block_tready", 32'(tready), 32'd0);
    chk("busy_block_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    comp_busy = 1'b0;

    // Nominal frame, back-to-back, with first-push latency check.
    lat_arm = 1'b1;
    send_frame(BEATS - 1, 0, 1'b0, 1'b1, acc0);
    wait_frame();
    chk("first_push_latency", 32'(first_push_cyc - acc0), 32'd2);

    send_frame(4, 100, 1'b0, 1'b1, dummy);
    wait_frame();
    send_frame(10, 200, 1'b0, 1'b1, dummy);
    wait_frame();

    for (int i = 0; i < 8; i++) begin
      send_frame($urandom_range(0, 11), $urandom_range(0, 30000), 1'b1, 1'b1, dummy);
      wait_frame();
    end

    // Reset mid-frame: outputs cleared, no rx_done, then a clean frame.
    mon_en = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(mk_beat(500, b), 1'b0, 1'b0, dummy);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("midreset");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_done", 32'(stray_done), 32'd0);
    mon_en = 1'b1;
    send_frame(BEATS - 1, 7, 1'b0, 1'b1, dummy);
    wait_frame();

    chk("fifo_max_count", 32'(max_cnt <= (1 << FAW)), 32'd1);
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
